multiplier_controller: RTL
==========================

MULTIPLIER_CONTROLLER -- requirements
Module: multiplier_controller

Interface
REQ-001 Parameter N, default 4, operand width in bits of the attached multiplier datapath; legal range N >= 2.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin one multiplication; sampled only in IDLE.
REQ-005 ack    input  1  acknowledges result; sampled only in DONE.
REQ-006 do_init  output  1  load datapath registers (accumulator cleared, multiplier loaded).
REQ-007 do_shift output  1  perform one add/shift step in the datapath.
REQ-008 busy   output  1  high while a multiplication is in progress (INIT or SHIFT).
REQ-009 done   output  1  high while the product is valid and held (DONE).
REQ-010 abort  input  1  present only when MULTIPLIER_CONTROLLER_ABORT_EN is defined (see Configuration).

Function
REQ-011 The block SHALL be a Moore FSM with states IDLE, INIT, SHIFT, DONE plus a step counter sized to hold 0..N-1.
REQ-012 All outputs SHALL be decoded from registered state only: IDLE all 0; INIT do_init=1, busy=1; SHIFT do_shift=1, busy=1; DONE done=1.
REQ-013 do_init and do_shift SHALL never be high in the same cycle.
REQ-014 IDLE -> INIT on a rising edge with start=1; otherwise stay in IDLE.
REQ-015 INIT SHALL last exactly one cycle, then go to SHIFT with counter=0.
REQ-016 In SHIFT, the counter SHALL increment each edge; when counter==N-1 the next edge SHALL go to DONE and clear the counter, giving exactly N consecutive do_shift cycles.
REQ-017 DONE SHALL hold until an edge with ack=1, then go to IDLE; ack outside DONE SHALL be ignored.
REQ-018 start outside IDLE SHALL be ignored; start=1 and ack=1 together in DONE SHALL go to IDLE only, so start must be re-sampled in IDLE.
REQ-019 Latency: from the edge sampling start, do_init high for cycle 1, do_shift high for cycles 2..N+1, done high from cycle N+2.
REQ-020 Back-to-back: start held high continuously SHALL begin a new operation on the edge after DONE->IDLE, i.e. one IDLE cycle minimum between operations.

Reset
REQ-021 reset=1 SHALL immediately, without waiting for clock, force state IDLE, counter 0, and do_init, do_shift, busy, done all 0.
REQ-022 Reset asserted mid-operation (INIT, SHIFT or DONE) SHALL abandon the operation; no further do_shift pulses until a new start after reset release.
REQ-023 First edge after reset deassertion SHALL already honour start=1.

Configuration
REQ-024 Macro MULTIPLIER_CONTROLLER_ABORT_EN SHALL compile in the abort port and behaviour.
REQ-025 With the macro defined: abort=1 at an edge in INIT or SHIFT SHALL go to IDLE and clear the counter; abort takes priority over start, ack and counter completion; abort in IDLE or DONE SHALL be ignored.
REQ-026 Without the macro: no abort port exists and REQ-014..REQ-020 are the complete transition set.

Verification
REQ-027 Reset: assert reset between edges with FSM in SHIFT -> all outputs 0 before next edge; counter 0 after release.
REQ-028 Nominal N=4: start pulsed one cycle -> do_init 1 cycle, do_shift exactly 4 cycles, done high from cycle 6; with attached datapath 11 x 6 -> product 66 when done=1.
REQ-029 Hold: ack held 0 for 5 cycles in DONE -> done stays 1, do_shift stays 0, product unchanged; ack=1 -> IDLE next edge.
REQ-030 Ignored inputs: start pulsed during SHIFT and ack pulsed during SHIFT -> shift count still 4, no extra do_init, done timing unchanged.
REQ-031 Back-to-back: start held 1 throughout, ack=1 in DONE -> one IDLE cycle, then second INIT; start+ack same edge in DONE -> IDLE, not INIT.
REQ-032 With MULTIPLIER_CONTROLLER_ABORT_EN: abort after 2nd do_shift -> IDLE next edge, total 2 do_shift pulses, done never asserted; abort in DONE ignored.

Source files
------------

// File: rtl/multiplier_controller.sv
// Sequencing controller for a shift-and-add multiplier datapath: one init cycle, N shift cycles, then hold.
// Optional abort input and behaviour compiled in with MULTIPLIER_CONTROLLER_ABORT_EN.
module multiplier_controller #(
    parameter int N = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic ack,
`ifdef MULTIPLIER_CONTROLLER_ABORT_EN
    input  logic abort,
`endif
    output logic do_init,
    output logic do_shift,
    output logic busy,
    output logic done
);

    // state | meaning
    // IDLE  | waiting for start
    // INIT  | datapath load, one cycle
    // SHIFT | one add/shift step per cycle, N cycles
    // DONE  | product valid, held until ack

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          abort_hit;

`ifdef MULTIPLIER_CONTROLLER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                state_next = SHIFT;
                count_next = '0;
            end
            SHIFT: begin
                if (count == LAST) begin
                    state_next = DONE;
                    count_next = '0;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            DONE: begin
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
        // Abort wins over counter completion; it has no effect once the product is held.
        if (abort_hit && (state == INIT || state == SHIFT)) begin
            state_next = IDLE;
            count_next = '0;
        end
    end

    always_comb begin
        do_init  = 1'b0;
        do_shift = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            INIT: begin
                do_init = 1'b1;
                busy    = 1'b1;
            end
            SHIFT: begin
                do_shift = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
